control_interface_output: RTL and testbench

CONTROL_INTERFACE_OUTPUT -- requirements
Module: control_interface_output

---
 rtl/control_interface_output_pkg.sv | 17 +
 rtl/control_interface_output_addr_counter.sv | 40 ++++
 rtl/control_interface_output.sv | 123 ++++++++++++
 tb/tb_control_interface_output.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/control_interface_output_pkg.sv
// Shared defaults and FSM encoding for the meter output interface.
// Imported by the top level and its word counter.
package control_interface_output_pkg;

  localparam int SINGLE_DEF     = 32;
  localparam int N_OUTPUT_DEF   = 8;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int INI_ADDR_DEF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SWAP = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/control_interface_output_addr_counter.sv
// Word index for a frame: cleared by start, advanced by count,
// saturating at the final word.
module output_addr_counter
  import control_interface_output_pkg::*;
#(
  parameter int N_OUTPUT   = N_OUTPUT_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  assign addr = cnt_q;
  assign last = (cnt_q == ADDR_WIDTH'(N_OUTPUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (count && !last) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_interface_output.sv
// Double-buffered result frame streamed word by word to the meter,
// with registered outputs and a sticky overrun flag.
module control_interface_output
  import control_interface_output_pkg::*;
#(
  parameter int SINGLE     = SINGLE_DEF,
  parameter int N_OUTPUT   = N_OUTPUT_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INI_ADDR   = INI_ADDR_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sta,
  input  logic [N_OUTPUT*SINGLE-1:0]   I_s,
  input  logic                         exchange_data_sig,
  output logic [SINGLE-1:0]            I_METERVI,
  output logic [ADDR_WIDTH-1:0]        addr_out,
  output logic                         valid_out,
  output logic                         done_sig,
  output logic                         overrun
);

  typedef logic [N_OUTPUT-1:0][SINGLE-1:0] bank_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(INI_ADDR);

  state_e                state_q, state_d;
  bank_t                 shadow_q, shadow_d;
  bank_t                 active_q, active_d;
  logic [SINGLE-1:0]     data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  ovr_q, ovr_d;

  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] nxt;
  logic                  last;

  output_addr_counter #(
    .N_OUTPUT   (N_OUTPUT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (state_q == ST_SWAP),
    .count (state_q == ST_SEND),
    .addr  (cnt),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (exchange_data_sig) state_d = ST_SWAP;
      ST_SWAP: state_d = ST_SEND;
      ST_SEND: if (last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_d = sta ? bank_t'(I_s) : shadow_q;
    active_d = (state_q == ST_SWAP) ? shadow_q : active_q;
    ovr_d    = ovr_q | (exchange_data_sig && state_q != ST_IDLE);
  end

  // Outputs are registered one word ahead: SWAP launches word 0,
  // each SEND cycle launches the word after the one on the bus.
  always_comb begin
    nxt     = cnt + ADDR_WIDTH'(1);
    data_d  = '0;
    addr_d  = BASE;
    valid_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_SWAP: begin
        data_d  = shadow_q[0];
        valid_d = 1'b1;
      end
      ST_SEND: begin
        if (last) begin
          done_d = 1'b1;
        end else begin
          data_d  = active_q[nxt];
          addr_d  = BASE + nxt;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      active_q <= '0;
      data_q   <= '0;
      addr_q   <= BASE;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign I_METERVI = data_q;
  assign addr_out  = addr_q;
  assign valid_out = valid_q;
  assign done_sig  = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_control_interface_output.sv
// Scoreboard bench: a frame-level model queues expected words and done
// pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_control_interface_output;

  localparam int SW  = 32;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int INI = 0;

  logic            clk = 1'b0;
  logic            rst, sta, ex;
  logic [N*SW-1:0] I_s;
  logic [SW-1:0]   I_METERVI;
  logic [AW-1:0]   addr_out;
  logic            valid_out, done_sig, overrun;

  control_interface_output #(
    .SINGLE     (SW),
    .N_OUTPUT   (N),
    .ADDR_WIDTH (AW),
    .INI_ADDR   (INI)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .sta               (sta),
    .I_s               (I_s),
    .exchange_data_sig (ex),
    .I_METERVI         (I_METERVI),
    .addr_out          (addr_out),
    .valid_out         (valid_out),
    .done_sig          (done_sig),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] data;
    logic [AW-1:0] addr;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  logic [31:0] m_shadow[N];
  int          free_at = 0;
  bit          m_ovr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] flt(input int v);
    int e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((v << (23 - e)) & 'h7FFFFF)};
  endfunction

  function automatic logic [N*SW-1:0] float_frame();
    logic [N*SW-1:0] f;
    for (int k = 0; k < N; k++) f[k*SW +: SW] = flt(k + 1);
    return f;
  endfunction

  function automatic logic [N*SW-1:0] rnd_frame();
    logic [N*SW-1:0] f;
    for (int k = 0; k < N; k++) f[k*SW +: SW] = $urandom;
    return f;
  endfunction

  // One clock cycle of stimulus; the model is updated after the edge
  // so the monitor sees expectations for the outputs of that edge.
  task automatic tick(input bit r, input bit s, input bit e,
                      input logic [N*SW-1:0] d);
    rst = r; sta = s; ex = e; I_s = d;
    @(posedge clk);
    cyc++;
    if (r) begin
      sbq.delete();
      foreach (m_shadow[k]) m_shadow[k] = '0;
      free_at = 0;
      m_ovr   = 0;
    end else begin
      if (s) for (int k = 0; k < N; k++) m_shadow[k] = d[k*SW +: SW];
      if (e) begin
        if (cyc >= free_at) begin
          for (int k = 0; k < N; k++)
            sbq.push_back('{0, m_shadow[k], AW'(INI + k), cyc + 1 + k});
          sbq.push_back('{1, 32'h0, AW'(INI), cyc + N + 1});
          free_at = cyc + N + 3;
        end else begin
          m_ovr = 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, '0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("overrun", overrun, m_ovr);
      if (valid_out || done_sig) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", {valid_out, done_sig}, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("kind_done", done_sig, mon_e.is_done);
          chk("kind_valid", valid_out, !mon_e.is_done);
          chk("timing", cyc, mon_e.cyc);
          if (!mon_e.is_done) begin
            chk("data", I_METERVI, mon_e.data);
            chk("addr", addr_out, mon_e.addr);
          end
        end
      end else begin
        chk("idle_data", I_METERVI, 0);
        chk("idle_addr", addr_out, AW'(INI));
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          chk("missing_output", 1, 0);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1; sta = 0; ex = 0; I_s = '0;
    tick(1, 0, 0, '0);
    mon_en = 1;
    tick(1, 0, 0, '0);

    // exchange straight after reset: zero frame
    tick(0, 0, 1, '0);
    idle(12);

    // float frame 1.0 .. 8.0
    idle(3);
    tick(0, 1, 0, float_frame());
    idle(9);
    tick(0, 0, 1, '0);
    idle(12);

    // sta and exchange in the same idle cycle
    tick(0, 1, 1, rnd_frame());
    idle(12);

    // sta during the 3rd SEND cycle goes to the next frame
    tick(0, 0, 1, '0);
    idle(3);
    tick(0, 1, 0, rnd_frame());
    idle(10);
    tick(0, 0, 1, '0);
    idle(12);

    // exchange mid-frame: ignored, overrun sticks
    tick(0, 0, 1, '0);
    idle(4);
    tick(0, 0, 1, '0);
    idle(14);

    // reset at the 4th SEND cycle, then a zero frame
    tick(0, 1, 0, rnd_frame());
    tick(0, 0, 1, '0);
    idle(4);
    tick(1, 0, 0, '0);
    idle(2);
    tick(0, 0, 1, '0);
    idle(12);

    for (int i = 0; i < 600; i++)
      tick($urandom_range(99) == 0, $urandom_range(7) == 0,
           $urandom_range(9) == 0, rnd_frame());

    idle(15);
    chk("drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
